// File: rtl/tinyalu_requester.sv
// tinyalu_requester: start/done initiator for a TinyALU with a valid/ready command and response port.
// Optional `TINYALU_REQ_CHECK_EN adds rsp_mismatch against a locally computed reference result.
module tinyalu_requester #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
`ifdef TINYALU_REQ_CHECK_EN
  , output logic      rsp_mismatch
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} state_t;
  state_t state_q, state_d;
  logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic alu_start_q, alu_start_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic rsp_timeout_q, rsp_timeout_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic cmd_legal;
  assign cmd_legal = (cmd_op != 3'd0) && (cmd_op <= 3'd4);
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_result = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign alu_A = alu_a_q;
  assign alu_B = alu_b_q;
  assign alu_op = alu_op_q;
  assign alu_start = alu_start_q;
  always_comb begin
    state_d = state_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_op_d = alu_op_q;
    alu_start_d = alu_start_q;
    rsp_result_d = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        alu_a_d = cmd_a;
        alu_b_d = cmd_b;
        alu_op_d = cmd_op;
        cnt_d = '0;
        rsp_result_d = '0;
        rsp_timeout_d = 1'b0;
        alu_start_d = cmd_legal;
        state_d = cmd_legal ? ISSUE : RESP;
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // done wins over an expiry landing in the same cycle
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_timeout_d = 1'b0;
          alu_start_d = 1'b0;
          state_d = GAP;
        end else if (cnt_d == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
          rsp_result_d = '0;
          rsp_timeout_d = 1'b1;
          alu_start_d = 1'b0;
          state_d = GAP;
        end
      end
      GAP: state_d = RESP;
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_op_q <= '0;
      alu_start_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_op_q <= alu_op_d;
      alu_start_q <= alu_start_d;
      rsp_result_q <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef TINYALU_REQ_CHECK_EN
  logic [15:0] ref_res;
  logic op_legal;
  assign op_legal = (alu_op_q != 3'd0) && (alu_op_q <= 3'd4);
  always_comb begin
    ref_res = alu_op_q == 3'd1 ? {7'd0, {1'b0, alu_a_q} + {1'b0, alu_b_q}} :
              alu_op_q == 3'd2 ? {8'd0, alu_a_q & alu_b_q} :
              alu_op_q == 3'd3 ? {8'd0, alu_a_q ^ alu_b_q} :
              alu_op_q == 3'd4 ? {8'd0, alu_a_q} * {8'd0, alu_b_q} : 16'd0;
  end
  assign rsp_mismatch = rsp_valid & ~rsp_timeout_q & op_legal & (rsp_result_q != ref_res);
`endif
endmodule

// File: tb/tb_tinyalu_requester.sv
// tb_tinyalu_requester: directed bench with a behavioural ALU and a response scoreboard.
module tb_tinyalu_requester;
  logic clk, reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic [7:0] cmd_a, cmd_b, alu_A, alu_B;
  logic [2:0] cmd_op, alu_op;
  logic [15:0] rsp_result, alu_result;
  logic alu_start, alu_done, busy;
`ifdef TINYALU_REQ_CHECK_EN
  logic rsp_mismatch;
`endif
  logic done_m, spur, hang;
  int mcnt, force_lat, checks, errors;
  typedef struct {logic [15:0] res; logic to;} exp_t;
  exp_t sb[$];

  tinyalu_requester dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
`ifdef TINYALU_REQ_CHECK_EN
    , .rsp_mismatch(rsp_mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd1: return {8'd0, a} + {8'd0, b};
      3'd2: return {8'd0, a & b};
      3'd3: return {8'd0, a ^ b};
      3'd4: return {8'd0, a} * {8'd0, b};
      default: return 16'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return force_lat != 0 ? force_lat : (op == 3'd4 ? 3 : 1);
  endfunction

  assign alu_done = done_m | spur;
  always @(posedge clk) begin
    if (reset || !alu_start) begin
      mcnt <= 0;
      done_m <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      done_m <= !hang && (mcnt + 1 == lat_of(alu_op));
      alu_result <= alu_fn(alu_A, alu_B, alu_op);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; stall holds rsp_ready low, qn queues the next command meanwhile.
  task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                     input logic [15:0] er, input logic et, input int el, input int esc,
                     input int stall, input bit qn, input logic [7:0] na, input logic [7:0] nb,
                     input logic [2:0] nop);
    int lat, sc;
    bit bl;
    exp_t e;
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    sb.push_back('{er, et});
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; sc = 0; bl = 0;
    while (!rsp_valid && lat < 64) begin
      if (alu_start) sc++;
      if (!busy) bl = 1;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_start_cycles"}, 32'(sc), 32'(esc));
    chk({tag, "_busy_held"}, 32'(bl), 32'd0);
    chk({tag, "_start_low_at_rsp"}, 32'(alu_start), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
      e = '{16'd0, 1'b0};
    end else e = sb.pop_front();
    for (int i = 0; i < stall; i++) begin
      if (qn) begin
        cmd_valid = 1'b1; cmd_a = na; cmd_b = nb; cmd_op = nop;
      end
      chk({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_stall_result"}, 32'(rsp_result), 32'(e.res));
      chk({tag, "_stall_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_stall_alu_A"}, 32'(alu_A), 32'(a));
      @(negedge clk);
    end
    chk({tag, "_result"}, 32'(rsp_result), 32'(e.res));
    chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.to));
`ifdef TINYALU_REQ_CHECK_EN
    chk({tag, "_mismatch"}, 32'(rsp_mismatch), 32'd0);
`endif
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_v, seen_s;
    checks = 0; errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; spur = 1'b0; hang = 1'b0; force_lat = 0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_alu_ops", 32'({alu_A, alu_B, alu_op}), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    txn("add", 8'hFF, 8'h01, 3'd1, 16'h0100, 1'b0, 4, 2, 0, 0, 0, 0, 0);
    txn("mul", 8'hFF, 8'hFF, 3'd4, 16'hFE01, 1'b0, 6, 4, 0, 0, 0, 0, 0);
    txn("noop", 8'h12, 8'h34, 3'd0, 16'h0000, 1'b0, 1, 0, 0, 0, 0, 0, 0);
    txn("illegal", 8'h56, 8'h78, 3'd6, 16'h0000, 1'b0, 1, 0, 0, 0, 0, 0, 0);
    hang = 1'b1;
    txn("timeout", 8'h11, 8'h22, 3'd1, 16'h0000, 1'b1, 17, 15, 0, 0, 0, 0, 0);
    hang = 1'b0;
    force_lat = 14;
    txn("done_at_expiry", 8'h12, 8'h34, 3'd1, 16'h0046, 1'b0, 17, 15, 0, 0, 0, 0, 0);
    force_lat = 0;
    txn("xor_stall", 8'hA5, 8'h0F, 3'd3, 16'h00AA, 1'b0, 4, 2, 5, 1, 8'h3C, 8'hF0, 3'd2);
    txn("and_queued", 8'h3C, 8'hF0, 3'd2, 16'h0030, 1'b0, 4, 2, 0, 0, 0, 0, 0);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("spur_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_a = 8'hFF; cmd_b = 8'hFF; cmd_op = 3'd4;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_start_before", 32'(alu_start), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_start", 32'(alu_start), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    seen_v = 0; seen_s = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_v++;
      if (alu_start) seen_s++;
    end
    rsp_ready = 1'b0;
    chk("rst_no_stale_rsp", 32'(seen_v), 32'd0);
    chk("rst_no_stale_start", 32'(seen_s), 32'd0);
    txn("add_after_rst", 8'h7F, 8'h80, 3'd1, 16'h00FF, 1'b0, 4, 2, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
